// File: rtl/bsg_mcl_rx_word_buffer_pkg.sv
// Shared types and constants for the AXI-Lite to manycore-link receive path.
package bsg_axil_to_mcl_pkg;

    // Width of one AXI-Lite data beat and of every buffered word.
    localparam int axil_data_width_gp = 32;

    // Receive word buffer control states.
    typedef enum logic [0:0] {
        E_IDLE  = 1'b0,
        E_SHIFT = 1'b1
    } rx_buf_state_e;

    // Index width for n entries, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        idx_width = (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/bsg_mcl_rx_word_buffer_if.sv
// Packet-in / word-out handshake bundle of one receive slot.
// slave: the word buffer; master: the endpoint plus AXI-Lite read slave.
interface bsg_mcl_rx_word_buffer_if
    import bsg_axil_to_mcl_pkg::*;
#(
    parameter int pkt_words_p = 4
);

    logic [pkt_words_p*axil_data_width_gp-1:0] pkt;
    logic                                       pkt_v;
    logic                                       pkt_ready;
    logic [axil_data_width_gp-1:0]              rx;
    logic                                       rx_v;
    logic                                       rx_ready;
    logic [axil_data_width_gp-1:0]              occupancy;

    modport slave (
        input  pkt,
        input  pkt_v,
        output pkt_ready,
        output rx,
        output rx_v,
        input  rx_ready,
        output occupancy
    );

    modport master (
        output pkt,
        output pkt_v,
        input  pkt_ready,
        input  rx,
        input  rx_v,
        output rx_ready,
        input  occupancy
    );

endinterface

// File: rtl/bsg_mcl_rx_word_buffer_fifo.sv
// 1r1w word FIFO with asynchronous-read head. Writes are assumed to have
// space reserved upstream; pops while empty are ignored.
module bsg_mcl_rx_word_fifo
    import bsg_axil_to_mcl_pkg::*;
#(
    parameter int els_p   = 16,
    parameter int width_p = 32
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             w_v,
    input  logic [width_p-1:0]               w_data,
    input  logic                             pop,
    output logic [width_p-1:0]               head,
    output logic                             head_v,
    output logic [$clog2(els_p+1)-1:0]       count
);

    localparam int ptr_w_lp = idx_width(els_p);
    localparam int cnt_w_lp = $clog2(els_p + 1);
    localparam logic [cnt_w_lp-1:0] cnt_one_lp = cnt_w_lp'(1);

    logic [width_p-1:0]  mem_r [els_p];
    logic [ptr_w_lp-1:0] wptr_r;
    logic [ptr_w_lp-1:0] rptr_r;
    logic [cnt_w_lp-1:0] count_r;
    logic [cnt_w_lp-1:0] count_next_s;
    logic                pop_s;

    // Pointer advance that wraps at the FIFO depth.
    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        if (p == ptr_w_lp'(els_p - 1)) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = p + ptr_w_lp'(1);
        end
    endfunction

    assign pop_s = pop & (count_r != '0);

    // Occupancy bookkeeping: a simultaneous write and pop cancel out.
    always_comb begin
        count_next_s = count_r;
        case ({w_v, pop_s})
            2'b10:   count_next_s = count_r + cnt_one_lp;
            2'b01:   count_next_s = count_r - cnt_one_lp;
            default: count_next_s = count_r;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (w_v) begin
                wptr_r <= ptr_inc(wptr_r);
            end
            if (pop_s) begin
                rptr_r <= ptr_inc(rptr_r);
            end
            count_r <= count_next_s;
        end
    end

    // Storage array; contents are meaningless until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (w_v) begin
            mem_r[wptr_r] <= w_data;
        end
    end

    assign head   = mem_r[rptr_r];
    assign head_v = (count_r != '0);
    assign count  = count_r;

endmodule

// File: rtl/bsg_mcl_rx_word_buffer.sv
// Receive word buffer for one manycore-link slot: admits whole packets only
// when the FIFO can absorb every word, then shifts them in word 0 first.
module bsg_mcl_rx_word_buffer
    import bsg_axil_to_mcl_pkg::*;
#(
    parameter int pkt_words_p = 4,
    parameter int fifo_els_p  = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    bsg_mcl_rx_word_buffer_if.slave   bus
);

    localparam int idx_w_lp = idx_width(pkt_words_p);
    localparam int cnt_w_lp = $clog2(fifo_els_p + 1);
    localparam logic [idx_w_lp-1:0] idx_last_lp = idx_w_lp'(pkt_words_p - 1);
    localparam logic [idx_w_lp-1:0] idx_one_lp  = idx_w_lp'(1);

    if ((fifo_els_p & (fifo_els_p - 1)) != 0) begin : g_bad_els_pow2
        $error("fifo_els_p must be a power of 2");
    end
    if (fifo_els_p < pkt_words_p) begin : g_bad_els_size
        $error("fifo_els_p must be at least pkt_words_p");
    end

    rx_buf_state_e                 state_r;
    rx_buf_state_e                 state_next_s;
    logic [axil_data_width_gp-1:0] buf_r [pkt_words_p];
    logic [idx_w_lp-1:0]           idx_r;
    logic [idx_w_lp-1:0]           idx_next_s;
    logic                          ready_en_r;
    logic                          pkt_ready_s;
    logic                          accept_s;
    logic                          fifo_w_v_s;
    logic                          has_space_s;
    logic [cnt_w_lp-1:0]           count_s;
    logic [cnt_w_lp-1:0]           free_s;
    logic [axil_data_width_gp-1:0] head_s;
    logic                          head_v_s;

    // Space for a full packet must exist before any of it is admitted.
    assign free_s      = cnt_w_lp'(fifo_els_p) - count_s;
    assign has_space_s = (free_s >= cnt_w_lp'(pkt_words_p));
    assign accept_s    = pkt_ready_s & bus.pkt_v;

    // Next-state, word index and FIFO write decode.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        fifo_w_v_s   = 1'b0;
        pkt_ready_s  = 1'b0;
        case (state_r)
            E_IDLE: begin
                pkt_ready_s = ready_en_r & has_space_s;
                if (pkt_ready_s & bus.pkt_v) begin
                    state_next_s = E_SHIFT;
                    idx_next_s   = '0;
                end else begin
                    state_next_s = E_IDLE;
                end
            end
            E_SHIFT: begin
                fifo_w_v_s = 1'b1;
                if (idx_r == idx_last_lp) begin
                    state_next_s = E_IDLE;
                    idx_next_s   = '0;
                end else begin
                    state_next_s = E_SHIFT;
                    idx_next_s   = idx_r + idx_one_lp;
                end
            end
            default: begin
                state_next_s = E_IDLE;
                idx_next_s   = '0;
            end
        endcase
    end

    // State and word index registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= E_IDLE;
            idx_r   <= '0;
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
        end
    end

    // Holds packet admission off while in reset and until the first edge after.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

    // Shift buffer captures the whole packet on acceptance.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < pkt_words_p; i++) begin
                buf_r[i] <= '0;
            end
        end else if (accept_s) begin
            for (int i = 0; i < pkt_words_p; i++) begin
                buf_r[i] <= bus.pkt[i*axil_data_width_gp +: axil_data_width_gp];
            end
        end
    end

    bsg_mcl_rx_word_fifo #(
        .els_p   (fifo_els_p),
        .width_p (axil_data_width_gp)
    ) fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .w_v       (fifo_w_v_s),
        .w_data    (buf_r[idx_r]),
        .pop       (bus.rx_ready),
        .head      (head_s),
        .head_v    (head_v_s),
        .count     (count_s)
    );

    assign bus.pkt_ready = pkt_ready_s;
    assign bus.rx        = head_s;
    assign bus.rx_v      = head_v_s;
    assign bus.occupancy = axil_data_width_gp'(count_s);

endmodule

// File: tb/tb_bsg_mcl_rx_word_buffer.sv
// Directed bench for bsg_mcl_rx_word_buffer (4 words/packet, 16-entry FIFO).
module tb_bsg_mcl_rx_word_buffer;

    localparam int PW = 4;
    localparam int FE = 16;

    logic clk;
    logic reset_n;
    int   tests;
    int   fails;

    bsg_mcl_rx_word_buffer_if #(.pkt_words_p(PW)) bus ();

    bsg_mcl_rx_word_buffer #(
        .pkt_words_p (PW),
        .fifo_els_p  (FE)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mk_pkt(input logic [31:0] base);
        mk_pkt = {base + 32'd3, base + 32'd2, base + 32'd1, base};
    endfunction

    // Check the head word, then pop it on the next edge.
    task automatic pop_expect(input string tag, input logic [31:0] exp);
        check({tag, "_v"}, {31'd0, bus.rx_v}, 32'd1);
        check(tag, bus.rx, exp);
        bus.rx_ready = 1'b1;
        step();
        bus.rx_ready = 1'b0;
    endtask

    // Offer one packet, assert it is accepted, then let the shift finish.
    task automatic send_pkt(input string tag, input logic [127:0] p);
        check(tag, {31'd0, bus.pkt_ready}, 32'd1);
        bus.pkt   = p;
        bus.pkt_v = 1'b1;
        step();
        bus.pkt_v = 1'b0;
        repeat (PW) step();
    endtask

    initial begin
        int n_in;
        int n_out;
        int cyc;
        logic acc;

        tests        = 0;
        fails        = 0;
        reset_n      = 1'b0;
        bus.pkt      = 128'h0;
        bus.pkt_v    = 1'b1;
        bus.rx_ready = 1'b0;

        // Reset with a valid packet offered.
        repeat (3) step();
        check("rst_pkt_ready", {31'd0, bus.pkt_ready}, 32'd0);
        check("rst_rx_v", {31'd0, bus.rx_v}, 32'd0);
        check("rst_occ", bus.occupancy, 32'd0);
        reset_n   = 1'b1;
        bus.pkt_v = 1'b0;
        step();
        check("rel_pkt_ready", {31'd0, bus.pkt_ready}, 32'd1);

        // Single packet, no pops during the shift.
        bus.pkt   = 128'h44444444_33333333_22222222_11111111;
        bus.pkt_v = 1'b1;
        step();
        bus.pkt_v = 1'b0;
        check("single_occ_e0", bus.occupancy, 32'd0);
        check("single_ready_shift", {31'd0, bus.pkt_ready}, 32'd0);
        step();
        check("single_occ_e1", bus.occupancy, 32'd1);
        check("single_rx_v_e1", {31'd0, bus.rx_v}, 32'd1);
        check("single_rx_e1", bus.rx, 32'h11111111);
        step();
        check("single_occ_e2", bus.occupancy, 32'd2);
        step();
        check("single_occ_e3", bus.occupancy, 32'd3);
        step();
        check("single_occ_e4", bus.occupancy, 32'd4);
        check("single_ready_e4", {31'd0, bus.pkt_ready}, 32'd1);
        pop_expect("single_pop0", 32'h11111111);
        pop_expect("single_pop1", 32'h22222222);
        pop_expect("single_pop2", 32'h33333333);
        pop_expect("single_pop3", 32'h44444444);
        check("single_rx_v_end", {31'd0, bus.rx_v}, 32'd0);
        check("single_occ_end", bus.occupancy, 32'd0);

        // Fill to 16 entries.
        for (int p = 0; p < 4; p++) begin
            send_pkt("full_accept", mk_pkt(32'h100 + 32'(p * 4)));
        end
        check("full_occ", bus.occupancy, 32'd16);
        check("full_ready", {31'd0, bus.pkt_ready}, 32'd0);
        pop_expect("full_pop0", 32'h100);
        check("full_ready_free1", {31'd0, bus.pkt_ready}, 32'd0);
        check("full_occ_free1", bus.occupancy, 32'd15);
        pop_expect("full_pop1", 32'h101);
        pop_expect("full_pop2", 32'h102);
        pop_expect("full_pop3", 32'h103);
        check("full_ready_free4", {31'd0, bus.pkt_ready}, 32'd1);
        check("full_occ_free4", bus.occupancy, 32'd12);
        for (int i = 4; i < 16; i++) begin
            pop_expect("full_drain", 32'h100 + 32'(i));
        end
        check("full_empty", {31'd0, bus.rx_v}, 32'd0);

        // Simultaneous write and pop at occupancy 5.
        send_pkt("sim_a", mk_pkt(32'hA0000000));
        send_pkt("sim_b", mk_pkt(32'hB0000000));
        pop_expect("sim_pre0", 32'hA0000000);
        pop_expect("sim_pre1", 32'hA0000001);
        pop_expect("sim_pre2", 32'hA0000002);
        check("sim_occ5", bus.occupancy, 32'd5);
        bus.pkt   = mk_pkt(32'hC0000000);
        bus.pkt_v = 1'b1;
        step();
        bus.pkt_v = 1'b0;
        check("sim_occ_e0", bus.occupancy, 32'd5);
        begin
            logic [31:0] exp_w [4];
            exp_w[0] = 32'hA0000003;
            exp_w[1] = 32'hB0000000;
            exp_w[2] = 32'hB0000001;
            exp_w[3] = 32'hB0000002;
            for (int k = 0; k < 4; k++) begin
                check("sim_rx", bus.rx, exp_w[k]);
                bus.rx_ready = 1'b1;
                step();
                check("sim_occ_hold", bus.occupancy, 32'd5);
            end
        end
        bus.rx_ready = 1'b0;
        pop_expect("sim_drain_b3", 32'hB0000003);
        for (int k = 0; k < 4; k++) begin
            pop_expect("sim_drain_c", 32'hC0000000 + 32'(k));
        end
        check("sim_occ_end", bus.occupancy, 32'd0);

        // Wrap-around with random pops.
        n_in      = 0;
        n_out     = 0;
        cyc       = 0;
        bus.pkt   = mk_pkt(32'h10000000);
        bus.pkt_v = 1'b1;
        while ((n_out < 40) && (cyc < 2000)) begin
            bus.rx_ready = 1'($urandom_range(0, 1));
            acc = bus.pkt_v & bus.pkt_ready;
            if (bus.rx_v && bus.rx_ready) begin
                check("wrap_word", bus.rx, 32'h10000000 + 32'(n_out));
                n_out++;
            end
            step();
            if (acc) begin
                n_in++;
                if (n_in == 10) begin
                    bus.pkt_v = 1'b0;
                end else begin
                    bus.pkt = mk_pkt(32'h10000000 + 32'(n_in * 4));
                end
            end
            cyc++;
        end
        bus.rx_ready = 1'b0;
        bus.pkt_v    = 1'b0;
        check("wrap_words_out", 32'(n_out), 32'd40);
        check("wrap_pkts_in", 32'(n_in), 32'd10);
        check("wrap_occ_end", bus.occupancy, 32'd0);

        // Asynchronous reset in the middle of a shift.
        bus.pkt   = mk_pkt(32'hD0000000);
        bus.pkt_v = 1'b1;
        step();
        bus.pkt_v = 1'b0;
        step();
        step();
        check("arst_occ_pre", bus.occupancy, 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_occ", bus.occupancy, 32'd0);
        check("arst_rx_v", {31'd0, bus.rx_v}, 32'd0);
        check("arst_ready", {31'd0, bus.pkt_ready}, 32'd0);
        step();
        reset_n = 1'b1;
        step();
        check("arst_rel_ready", {31'd0, bus.pkt_ready}, 32'd1);
        bus.pkt   = mk_pkt(32'hE0000000);
        bus.pkt_v = 1'b1;
        step();
        bus.pkt_v = 1'b0;
        step();
        check("arst_new_occ", bus.occupancy, 32'd1);
        check("arst_new_rx", bus.rx, 32'hE0000000);
        repeat (3) step();
        check("arst_new_occ4", bus.occupancy, 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
